// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mc_pkg
// Brief   : Shared encodings for the multi-cycle control unit.
// Revision: 1.0
// ============================================================================
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_LW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_BNE  = 3'd4,
    CLS_JAL  = 3'd5,
    CLS_JR   = 3'd6
  } instr_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SLT  = 2'b01;
  localparam logic [1:0] ALU_ADDI = 2'b10;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;
  localparam logic [1:0] PC_SEL_REG = 2'd3;

  typedef struct packed {
    instr_cls_e cls;
    logic [1:0] alu_op;
    logic       writes_rf;
    logic       is_mem;
    logic       invalid;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module  : mc_decode
// Brief   : Combinational opcode/funct classifier for the control FSM.
// Revision: 1.0
// ============================================================================
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CLS_NONE, alu_op: ALU_ADD, writes_rf: 1'b0, is_mem: 1'b0, invalid: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin dec.cls = CLS_ALU; dec.alu_op = ALU_ADD; dec.writes_rf = 1'b1; end
          FN_SLT:  begin dec.cls = CLS_ALU; dec.alu_op = ALU_SLT; dec.writes_rf = 1'b1; end
          FN_JR:   dec.cls = CLS_JR;
          default: dec.invalid = 1'b1;
        endcase
      end
      OP_ADDIU: begin dec.cls = CLS_ALU; dec.alu_op = ALU_ADDI; dec.writes_rf = 1'b1; end
      OP_LW: begin
        dec.cls       = CLS_LW;
        dec.alu_op    = ALU_ADDI;
        dec.writes_rf = 1'b1;
        dec.is_mem    = 1'b1;
      end
      OP_BEQ:  dec.cls = CLS_BEQ;
      OP_BNE:  dec.cls = CLS_BNE;
      OP_JAL:  dec.cls = CLS_JAL;
      default: dec.invalid = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : mc_control_unit
// Brief   : Multi-cycle control FSM with a req/ready data-memory handshake.
// Revision: 1.0
// ============================================================================
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int MAX_PC = 11,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             eq_flag,
  input  logic             dest_is_zero,
  input  logic [7:0]       pc,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ir_we,
  output logic             rf_read_en,
  output logic [1:0]       alu_op,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             link_we,
  output logic             mem_req,
  output logic             wb_src,
  output logic             rf_we,
  output logic             invalid,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] invalid_cnt
);

  localparam logic [7:0]       C_MAX_PC  = 8'(MAX_PC);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_e           r_state, w_state_nxt;
  dec_t             w_dec;
  instr_cls_e       r_cls;
  logic [1:0]       r_alu_op;
  logic             r_writes_rf, r_is_mem, r_invalid;
  logic [CNT_W-1:0] r_retired, r_invalid_cnt;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (w_dec)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:  w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_READ;
      ST_READ:   w_state_nxt = ST_EXEC;
      ST_EXEC:   w_state_nxt = ST_MEM;
      ST_MEM:    w_state_nxt = (r_is_mem && !mem_ready) ? ST_MEM : ST_WB;
      ST_WB:     w_state_nxt = (pc >= C_MAX_PC) ? ST_HALT : ST_FETCH;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // Strobes decode the registered state; ir_we is masked so FETCH under reset stays quiet.
  always_comb begin
    ir_we      = 1'b0;
    rf_read_en = 1'b0;
    alu_op     = ALU_ADD;
    pc_we      = 1'b0;
    pc_src     = PC_SEL_SEQ;
    link_we    = 1'b0;
    mem_req    = 1'b0;
    wb_src     = 1'b0;
    rf_we      = 1'b0;
    case (r_state)
      ST_FETCH: ir_we = !rst;
      ST_READ:  rf_read_en = 1'b1;
      ST_EXEC: begin
        pc_we  = 1'b1;
        alu_op = r_alu_op;
        case (r_cls)
          CLS_BEQ: pc_src = eq_flag ? PC_SEL_BR : PC_SEL_SEQ;
          CLS_BNE: pc_src = eq_flag ? PC_SEL_SEQ : PC_SEL_BR;
          CLS_JAL: begin pc_src = PC_SEL_JMP; link_we = 1'b1; end
          CLS_JR:  pc_src = PC_SEL_REG;
          default: pc_src = PC_SEL_SEQ;
        endcase
      end
      ST_MEM: mem_req = r_is_mem;
      ST_WB: begin
        rf_we  = r_writes_rf && !r_invalid && !dest_is_zero;
        wb_src = (r_cls == CLS_LW);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_cls         <= CLS_NONE;
      r_alu_op      <= ALU_ADD;
      r_writes_rf   <= 1'b0;
      r_is_mem      <= 1'b0;
      r_invalid     <= 1'b0;
      r_retired     <= '0;
      r_invalid_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_DECODE) begin
        r_cls       <= w_dec.cls;
        r_alu_op    <= w_dec.alu_op;
        r_writes_rf <= w_dec.writes_rf;
        r_is_mem    <= w_dec.is_mem;
        r_invalid   <= w_dec.invalid;
      end else if (w_state_nxt == ST_FETCH) begin
        r_invalid <= 1'b0;
      end
      if (r_state == ST_WB) begin
        r_retired <= r_retired + C_CNT_ONE;
        if (r_invalid) r_invalid_cnt <= r_invalid_cnt + C_CNT_ONE;
      end
    end
  end

  assign state       = r_state;
  assign invalid     = r_invalid;
  assign halted      = (r_state == ST_HALT);
  assign retired     = r_retired;
  assign invalid_cnt = r_invalid_cnt;

endmodule
`default_nettype wire
